mod_counter: RTL and testbench

- Parametrised successor to the team's 4-bit free-running counter.
- Programmable width and modulus, up/down direction, synchronous clear and parallel load, and wrap or saturate mode.
- Registered terminal-count pulse and sticky overflow flag.
- Used as the general-purpose event/timebase counter in control paths (BCD digits, dividers, timeout timers).

---
 rtl/counter_pkg.sv | 23 ++
 rtl/mod_counter_next.sv | 84 ++++++++
 rtl/mod_counter.sv | 95 +++++++++
 tb/tb_mod_counter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared constants and helpers for the mod_counter family.
//   - DIR_UP / DIR_DOWN : encodings of the up_down input.
//   - MODE_WRAP / MODE_SAT : legal values of the SATURATE parameter.
//   - clamp_load()      : limits a parallel-load value to the top of the range.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Returns value if it lies in 0..mod-1, otherwise mod-1. Operands are kept
    // at 32 bits so the helper serves every counter width up to 32.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] mod);
        return (value <= mod - 32'd1) ? value : mod - 32'd1;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// -----------------------------------------------------------------------------
// mod_counter_next
//   Combinational next-state logic for mod_counter.
//   Priority: clear > load > enable step > hold.
//   Ports:
//     count_i          current count
//     up_down_i        step direction (DIR_UP / DIR_DOWN)
//     enable_i         take one step this cycle
//     clear_i          force next count to 0
//     load_i           take (clamped) load_value_i
//     load_value_i     parallel-load value
//     next_count_o     count for the next cycle
//     boundary_event_o step attempted past 0 or MOD-1 (wrap or blocked step)
// -----------------------------------------------------------------------------
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_down_i,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             boundary_event_o
);

    // One extra bit of headroom: MOD-1 and count+1 are always representable,
    // so the range never depends on natural binary rollover.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
    localparam logic           SAT = (SATURATE == MODE_SAT);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] next_ext;
    logic [31:0]    clamped;
    logic           unused_bits;

    assign count_ext = {1'b0, count_i};
    assign clamped   = clamp_load(32'(load_value_i), 32'(MOD));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        next_ext         = count_ext;
        boundary_event_o = 1'b0;
        if (clear_i) begin
            next_ext = '0;
        end else if (load_i) begin
            next_ext = (WIDTH+1)'(clamped);
        end else if (enable_i) begin
            case (up_down_i)
                DIR_UP: begin
                    if (count_ext == TOP) begin
                        boundary_event_o = 1'b1;
                        next_ext         = SAT ? TOP : '0;
                    end else begin
                        next_ext = count_ext + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (count_ext == '0) begin
                        boundary_event_o = 1'b1;
                        next_ext         = SAT ? '0 : TOP;
                    end else begin
                        next_ext = count_ext - ONE;
                    end
                end
                default: begin
                    next_ext = count_ext;
                end
            endcase
        end
    end

    // next_ext never exceeds MOD-1, so its top bit is always zero.
    assign next_count_o = next_ext[WIDTH-1:0];
    assign unused_bits  = ^{next_ext[WIDTH], clamped};

endmodule

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Parametrised modulo counter: up/down, synchronous clear and parallel load,
//   wrap or saturate at the range boundary, registered terminal-count pulse and
//   sticky overflow flag.
//   Parameters: WIDTH (count bits), MOD (range 0..MOD-1, 2..2**WIDTH),
//               SATURATE (MODE_WRAP / MODE_SAT).
//   Ports:
//     clk, reset_n  rising-edge clock, asynchronous active-low reset
//     enable        step once this cycle
//     up_down       direction, 1 = up, 0 = down
//     clear         synchronous clear of count (ovf untouched)
//     load          synchronous load of load_value (clamped to MOD-1)
//     ovf_clr       clears the sticky ovf flag
//     count         registered count
//     tc            one-cycle pulse after each boundary event
//     ovf           sticky boundary-event flag
// -----------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "mod_counter: WIDTH must be 1..32");
    end
    if (MOD < 2 || 64'(MOD) > (64'd1 << WIDTH)) begin : g_bad_mod
        $fatal(1, "mod_counter: MOD must be 2..2**WIDTH");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $fatal(1, "mod_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             boundary_event;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i          (count_q),
        .up_down_i        (up_down),
        .enable_i         (enable),
        .clear_i          (clear),
        .load_i           (load),
        .load_value_i     (load_value),
        .next_count_o     (count_d),
        .boundary_event_o (boundary_event)
    );

    // Clear and load never raise a boundary event, so tc drops on them too.
    assign tc_d  = boundary_event;
    // A new boundary event outranks a simultaneous ovf_clr.
    assign ovf_d = boundary_event | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//   Directed bench for mod_counter. Three instances share the control inputs:
//     u_wrap : WIDTH=4, MOD=10,  wrap
//     u_sat  : WIDTH=4, MOD=10,  saturate
//     u_big  : WIDTH=8, MOD=256, wrap
//   Each phase starts from reset and checks only the instance it targets.
// -----------------------------------------------------------------------------
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       up_down;
    logic       clear;
    logic       load;
    logic       ovf_clr;
    logic [3:0] lv4;
    logic [7:0] lv8;

    logic [3:0] cnt_w, cnt_s;
    logic [7:0] cnt_b;
    logic       tc_w, tc_s, tc_b;
    logic       ovf_w, ovf_s, ovf_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(lv4), .ovf_clr(ovf_clr),
        .count(cnt_w), .tc(tc_w), .ovf(ovf_w)
    );

    mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(lv4), .ovf_clr(ovf_clr),
        .count(cnt_s), .tc(tc_s), .ovf(ovf_s)
    );

    mod_counter #(.WIDTH(8), .MOD(256), .SATURATE(0)) u_big (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(lv8), .ovf_clr(ovf_clr),
        .count(cnt_b), .tc(tc_b), .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        up_down = 1'b1;
        clear   = 1'b0;
        load    = 1'b0;
        ovf_clr = 1'b0;
        lv4     = '0;
        lv8     = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int sat_cnt[5] = '{8, 9, 9, 9, 9};
    int sat_tc[5]  = '{0, 0, 1, 1, 1};

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        up_down = 1'b1;
        clear   = 1'b0;
        load    = 1'b0;
        ovf_clr = 1'b0;
        lv4     = '0;
        lv8     = '0;

        // Reset state, before any clock edge.
        #3;
        check("rst_count", cnt_w, 0);
        check("rst_tc",    tc_w,  0);
        check("rst_ovf",   ovf_w, 0);
        check("rst_big",   cnt_b, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("hold_after_release", cnt_w, 0);

        // 1: up-count through the MOD=10 wrap.
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("up_wrap_count", cnt_w, i % 10);
            check("up_wrap_tc",    tc_w,  (i == 10) ? 1 : 0);
        end
        check("up_wrap_ovf", ovf_w, 1);

        // 2: down wrap from reset, ovf_clr alone, ovf_clr against a wrap.
        do_reset();
        enable  = 1'b1;
        up_down = 1'b0;
        step();
        check("down_wrap_count", cnt_w, 9);
        check("down_wrap_tc",    tc_w,  1);
        check("down_wrap_ovf",   ovf_w, 1);
        enable = 1'b0;
        step();
        check("idle_count", cnt_w, 9);
        check("idle_tc",    tc_w,  0);
        check("idle_ovf",   ovf_w, 1);
        ovf_clr = 1'b1;
        step();
        check("ovf_clr_alone", ovf_w, 0);
        ovf_clr = 1'b0;
        load    = 1'b1;
        lv4     = 4'd0;
        step();
        check("load0_count", cnt_w, 0);
        check("load0_tc",    tc_w,  0);
        load    = 1'b0;
        enable  = 1'b1;
        ovf_clr = 1'b1;
        step();
        check("set_vs_clr_count", cnt_w, 9);
        check("set_vs_clr_tc",    tc_w,  1);
        check("set_vs_clr_ovf",   ovf_w, 1);
        enable = 1'b0;
        step();
        check("ovf_clr_after", ovf_w, 0);
        check("tc_after",      tc_w,  0);
        ovf_clr = 1'b0;

        // 3: saturate mode at both ends.
        do_reset();
        load = 1'b1;
        lv4  = 4'd7;
        step();
        check("sat_load7", cnt_s, 7);
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_up_count", cnt_s, sat_cnt[i]);
            check("sat_up_tc",    tc_s,  sat_tc[i]);
        end
        check("sat_up_ovf", ovf_s, 1);
        enable = 1'b0;
        load   = 1'b1;
        lv4    = 4'd0;
        step();
        check("sat_load0",    cnt_s, 0);
        check("sat_load0_tc", tc_s,  0);
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b0;
        repeat (2) begin
            step();
            check("sat_down_count", cnt_s, 0);
            check("sat_down_tc",    tc_s,  1);
        end
        up_down = 1'b1;
        step();
        check("sat_turn_count", cnt_s, 1);
        check("sat_turn_tc",    tc_s,  0);
        enable = 1'b0;

        // 4: priority clear > load > step, and load clamping.
        do_reset();
        load = 1'b1;
        lv4  = 4'd9;
        step();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        step();
        check("prio_wrap_count", cnt_w, 0);
        check("prio_wrap_ovf",   ovf_w, 1);
        clear = 1'b1;
        load  = 1'b1;
        lv4   = 4'd5;
        step();
        check("prio_clear_count", cnt_w, 0);
        check("prio_clear_tc",    tc_w,  0);
        check("prio_clear_ovf",   ovf_w, 1);
        clear = 1'b0;
        lv4   = 4'd12;
        step();
        check("clamp_count", cnt_w, 9);
        check("clamp_tc",    tc_w,  0);
        load   = 1'b0;
        enable = 1'b0;

        // 5: asynchronous reset in the middle of counting.
        do_reset();
        load = 1'b1;
        lv4  = 4'd9;
        step();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        step();
        check("pre_rst_ovf", ovf_w, 1);
        repeat (6) step();
        check("pre_rst_count", cnt_w, 6);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_count", cnt_w, 0);
        check("async_rst_tc",    tc_w,  0);
        check("async_rst_ovf",   ovf_w, 0);
        repeat (3) begin
            step();
            check("rst_held_count", cnt_w, 0);
        end
        reset_n = 1'b1;
        step();
        check("post_rst_count", cnt_w, 1);
        enable = 1'b0;

        // 6: full-range modulus wraps 255 -> 0.
        do_reset();
        load = 1'b1;
        lv8  = 8'd255;
        step();
        check("big_load", cnt_b, 255);
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        step();
        check("big_wrap_count", cnt_b, 0);
        check("big_wrap_tc",    tc_b,  1);
        check("big_wrap_ovf",   ovf_b, 1);
        step();
        check("big_next_count", cnt_b, 1);
        check("big_next_tc",    tc_b,  0);
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
